pll_lock_seq: RTL and testbench

Reset and lock sequencer for the fabric PLL. It runs on the free-running 24 MHz board reference clock that also feeds the PLL, and drives the PLL `reset` pin. It qualifies the asynchronous `lock` output, retries failed lock attempts, and recovers from loss of lock. It publishes a registered `pll_ready` that downstream clock domains synchronize before releasing their own resets.

---
 rtl/pll_lock_seq.sv | 145 ++++++++++++++
 tb/tb_pll_lock_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies the synchronized lock, retries on timeout, and re-sequences on lock loss.
// All outputs are registered and decoded from the next state; lock_s trails the raw lock input by 2 cycles.
module pll_lock_seq #(
  parameter int unsigned RST_PULSE_CYCLES    = 24,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 24000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 2400,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_READY     = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_reset_q, pll_reset_d;
  logic             pll_ready_q, pll_ready_d;
  logic             pll_fail_q, pll_fail_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (relock_req) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // A lock arriving on the timeout cycle still counts as a lock.
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READY: begin
          if (!lock_s_q) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    pll_ready_d = (state_d == S_READY);
    pll_fail_d  = (state_d == S_FAIL);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      pll_ready_q <= 1'b0;
      pll_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;
      pll_reset_q <= pll_reset_d;
      pll_ready_q <= pll_ready_d;
      pll_fail_q  <= pll_fail_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign pll_ready = pll_ready_q;
  assign pll_fail  = pll_fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq with short timings: RST_PULSE=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2.
module tb_pll_lock_seq;

  logic       clkin = 1'b0;
  logic       reset;
  logic       lock;
  logic       relock_req;
  logic       pll_reset;
  logic       pll_ready;
  logic       pll_fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  pll_lock_seq #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .lock      (lock),
    .relock_req(relock_req),
    .pll_reset (pll_reset),
    .pll_ready (pll_ready),
    .pll_fail  (pll_fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int         n;
    logic       rst;
    logic       lk;
    logic       rq;
    logic [2:0] st;
    logic       prst;
    logic       rdy;
    logic       fl;
    logic [3:0] rc;
    logic [7:0] lc;
  } vec_t;

  vec_t vec [15];
  logic [2:0] st_log [0:80];

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic lk);
    lock       = lk;
    relock_req = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    int lo_cnt;
    logic rst_seen;

    reset      = 1'b1;
    lock       = 1'b0;
    relock_req = 1'b0;

    // Nominal lock, then loss while READY and re-lock: {n, rst, lock, relock, state, pll_reset, ready, fail, retry, loss}
    vec[0]  = '{2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vec[1]  = '{3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vec[2]  = '{1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vec[3]  = '{9, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vec[4]  = '{2, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vec[5]  = '{1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vec[6]  = '{7, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vec[7]  = '{1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
    vec[8]  = '{2, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
    vec[9]  = '{1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vec[10] = '{3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vec[11] = '{1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1};
    vec[12] = '{1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1};
    vec[13] = '{7, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1};
    vec[14] = '{1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1};

    for (int i = 0; i < 15; i++) begin
      reset      = vec[i].rst;
      lock       = vec[i].lk;
      relock_req = vec[i].rq;
      for (int k = 0; k < vec[i].n; k++) tick();
      chk($sformatf("vec%0d state", i),     32'(state),     32'(vec[i].st));
      chk($sformatf("vec%0d pll_reset", i), 32'(pll_reset), 32'(vec[i].prst));
      chk($sformatf("vec%0d pll_ready", i), 32'(pll_ready), 32'(vec[i].rdy));
      chk($sformatf("vec%0d pll_fail", i),  32'(pll_fail),  32'(vec[i].fl));
      chk($sformatf("vec%0d retry_cnt", i), 32'(retry_cnt), 32'(vec[i].rc));
      chk($sformatf("vec%0d loss_cnt", i),  32'(loss_cnt),  32'(vec[i].lc));
    end

    // Second loss from READY, then one timeout to reach WAIT_LOCK with retry_cnt=1, then reset.
    lock = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 3) begin
        chk("loss2 state", 32'(state), 32'd0);
        chk("loss2 loss_cnt", 32'(loss_cnt), 32'd2);
      end
    end
    chk("midrst pre state", 32'(state), 32'd1);
    chk("midrst pre retry", 32'(retry_cnt), 32'd1);
    chk("midrst pre loss", 32'(loss_cnt), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst state", 32'(state), 32'd0);
    chk("midrst retry", 32'(retry_cnt), 32'd0);
    chk("midrst loss", 32'(loss_cnt), 32'd0);
    chk("midrst pll_reset", 32'(pll_reset), 32'd1);
    chk("midrst pll_ready", 32'(pll_ready), 32'd0);
    hi_cnt = 1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (pll_reset) hi_cnt++;
    end
    chk("midrst pulse len", 32'(hi_cnt), 32'd4);
    chk("midrst after state", 32'(state), 32'd1);

    // One-cycle lock glitch while STABLE.
    do_reset(1'b1);
    rst_seen = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      st_log[e] = state;
      if (e >= 5 && pll_reset) rst_seen = 1'b1;
      if (e == 9)  lock = 1'b0;
      if (e == 10) lock = 1'b1;
    end
    chk("glitch e4 state", 32'(st_log[4]), 32'd1);
    chk("glitch e5 state", 32'(st_log[5]), 32'd2);
    chk("glitch e11 state", 32'(st_log[11]), 32'd2);
    chk("glitch e12 state", 32'(st_log[12]), 32'd1);
    chk("glitch e13 state", 32'(st_log[13]), 32'd2);
    chk("glitch e20 state", 32'(st_log[20]), 32'd2);
    chk("glitch e21 state", 32'(st_log[21]), 32'd3);
    chk("glitch no pll_reset", 32'(rst_seen), 32'd0);

    // Never lock: three attempts then FAIL at edge 72.
    do_reset(1'b0);
    hi_cnt = 0;
    lo_cnt = 0;
    for (int e = 1; e <= 72; e++) begin
      tick();
      st_log[e] = state;
      if (e <= 71) begin
        if (pll_reset) hi_cnt++;
        else lo_cnt++;
      end
      if (e == 24) chk("nolock e24 retry", 32'(retry_cnt), 32'd1);
    end
    chk("nolock high cycles", 32'(hi_cnt), 32'd11);
    chk("nolock low cycles", 32'(lo_cnt), 32'd60);
    chk("nolock e71 state", 32'(st_log[71]), 32'd1);
    chk("nolock e72 state", 32'(st_log[72]), 32'd4);
    chk("nolock pll_fail", 32'(pll_fail), 32'd1);
    chk("nolock pll_reset", 32'(pll_reset), 32'd1);
    chk("nolock retry", 32'(retry_cnt), 32'd2);
    tick();
    tick();
    chk("fail hold state", 32'(state), 32'd4);

    // relock_req from FAIL.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("relock fail state", 32'(state), 32'd0);
    chk("relock fail pll_fail", 32'(pll_fail), 32'd0);
    chk("relock fail retry", 32'(retry_cnt), 32'd0);
    chk("relock fail pll_reset", 32'(pll_reset), 32'd1);
    hi_cnt = 1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (pll_reset) hi_cnt++;
    end
    chk("relock pulse len", 32'(hi_cnt), 32'd4);
    chk("relock after state", 32'(state), 32'd1);

    // relock_req coinciding with lock loss in READY.
    do_reset(1'b1);
    for (int e = 1; e <= 13; e++) tick();
    chk("rq ready state", 32'(state), 32'd3);
    lock = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("rq loss state", 32'(state), 32'd0);
    chk("rq loss pll_ready", 32'(pll_ready), 32'd0);
    chk("rq loss loss_cnt", 32'(loss_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
